// File: rtl/accum_buffer_arbiter.sv
// accum_buffer_arbiter
// Round-robin arbiter that drains NUM_SRC worker accumulate FIFOs into a
// single accumulate buffer, taking up to BURST_LEN words per grant.
// Build option: define ACCUM_ARB_NAN_FREEZE_EN to forward a word whose value
// field is the quiet NaN 32'h7FC00000 and then freeze (FREEZE) until reset.
//
// Handshake: sources are non-show-ahead FIFOs. src_rdreq[i] is a one-cycle
// pulse issued only for a source seen non-empty in the deciding cycle, and the
// word is on src_dataout one cycle later. sink_wrreq is a one-cycle write strobe
// with sink_datain valid in the same cycle; it is issued only when sink_full
// was low in the WRITE cycle that produced it.
module accum_buffer_arbiter #(
    parameter int NUM_SRC   = 4,
    parameter int BURST_LEN = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [NUM_SRC-1:0]      src_empty,
    input  logic [64*NUM_SRC-1:0]   src_dataout,
    output logic [NUM_SRC-1:0]      src_rdreq,
    input  logic                    sink_full,
    output logic                    sink_wrreq,
    output logic [63:0]             sink_datain,
    output logic [3:0]              grant_id,
    output logic                    busy,
    output logic [31:0]             words_fwd
);

`ifdef ACCUM_ARB_NAN_FREEZE_EN
    localparam logic [31:0] NAN_VALUE = 32'h7FC0_0000;
    typedef enum logic [2:0] {S_IDLE, S_READ, S_CAPTURE, S_WRITE, S_FREEZE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_READ, S_CAPTURE, S_WRITE} state_t;
`endif

    state_t               state_q, state_d;
    logic [3:0]           rr_ptr_q, rr_ptr_d;
    logic [7:0]           burst_cnt_q, burst_cnt_d;
    logic [63:0]          hold_q, hold_d;
    logic [NUM_SRC-1:0]   rdreq_q, rdreq_d;
    logic                 wrreq_q, wrreq_d;
    logic [63:0]          datain_q, datain_d;
    logic [3:0]           grant_q, grant_d;
    logic                 busy_q, busy_d;
    logic [31:0]          words_q, words_d;

    // Padded views so a 4-bit source index can address any source directly.
    logic [15:0]          empty16;
    logic [1023:0]        data16;
    logic [4:0]           cand;
    logic                 found;
    logic [3:0]           pick;
    logic [3:0]           next_ptr;
    logic                 more_burst;

    function automatic logic [NUM_SRC-1:0] onehot(input logic [3:0] idx);
        logic [NUM_SRC-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_SRC; i++) v[i] = (idx == 4'(i));
        return v;
    endfunction

    // Pad the per-source empty flags and data words out to 16 sources.
    always_comb begin
        empty16 = {16{1'b1}};
        empty16[NUM_SRC-1:0] = src_empty;
        data16 = '0;
        data16[64*NUM_SRC-1:0] = src_dataout;
    end

    // Round-robin search: first non-empty source at or above rr_ptr, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            cand = {1'b0, rr_ptr_q} + 5'(i);
            if (cand >= 5'(NUM_SRC)) cand = cand - 5'(NUM_SRC);
            if (!found && !empty16[cand[3:0]]) begin
                found = 1'b1;
                pick  = cand[3:0];
            end
        end
    end

    // Burst continuation test and the pointer used when a burst ends.
    always_comb begin
        next_ptr   = (grant_q == 4'(NUM_SRC - 1)) ? 4'd0 : grant_q + 4'd1;
        more_burst = enable && !empty16[grant_q] &&
                     (({1'b0, burst_cnt_q} + 9'd1) < 9'(BURST_LEN));
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        hold_d      = hold_q;
        rdreq_d     = '0;
        wrreq_d     = 1'b0;
        datain_d    = datain_q;
        grant_d     = grant_q;
        words_d     = words_q;
        case (state_q)
            S_IDLE: begin
                if (enable && found) begin
                    grant_d     = pick;
                    burst_cnt_d = '0;
                    rdreq_d     = onehot(pick);
                    state_d     = S_READ;
                end
            end
            S_READ: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                hold_d  = data16[{grant_q, 6'b0} +: 64];
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (!sink_full) begin
                    wrreq_d     = 1'b1;
                    datain_d    = hold_q;
                    words_d     = words_q + 32'd1;
                    burst_cnt_d = burst_cnt_q + 8'd1;
`ifdef ACCUM_ARB_NAN_FREEZE_EN
                    if (hold_q[31:0] == NAN_VALUE) begin
                        state_d = S_FREEZE;
                    end else
`endif
                    if (more_burst) begin
                        rdreq_d = onehot(grant_q);
                        state_d = S_READ;
                    end else begin
                        rr_ptr_d = next_ptr;
                        state_d  = S_IDLE;
                    end
                end
            end
`ifdef ACCUM_ARB_NAN_FREEZE_EN
            S_FREEZE: begin
                state_d = S_FREEZE;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset discards any in-flight word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            hold_q      <= '0;
            rdreq_q     <= '0;
            wrreq_q     <= 1'b0;
            datain_q    <= '0;
            grant_q     <= '0;
            busy_q      <= 1'b0;
            words_q     <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            hold_q      <= hold_d;
            rdreq_q     <= rdreq_d;
            wrreq_q     <= wrreq_d;
            datain_q    <= datain_d;
            grant_q     <= grant_d;
            busy_q      <= busy_d;
            words_q     <= words_d;
        end
    end

    assign src_rdreq   = rdreq_q;
    assign sink_wrreq  = wrreq_q;
    assign sink_datain = datain_q;
    assign grant_id    = grant_q;
    assign busy        = busy_q;
    assign words_fwd   = words_q;

endmodule

// File: tb/tb_accum_buffer_arbiter.sv
// Testbench for accum_buffer_arbiter: source FIFO models, a round-robin
// reference model feeding an expected queue, and a negedge monitor.
`timescale 1ns/1ps
module tb_accum_buffer_arbiter;
  localparam int NUM_SRC   = 4;
  localparam int BURST_LEN = 4;
  localparam int DEPTH     = 64;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  enable;
  logic [NUM_SRC-1:0]    src_empty;
  logic [64*NUM_SRC-1:0] src_dataout;
  logic [NUM_SRC-1:0]    src_rdreq;
  logic                  sink_full;
  logic                  sink_wrreq;
  logic [63:0]           sink_datain;
  logic [3:0]            grant_id;
  logic                  busy;
  logic [31:0]           words_fwd;

  accum_buffer_arbiter #(.NUM_SRC(NUM_SRC), .BURST_LEN(BURST_LEN)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .src_empty(src_empty), .src_dataout(src_dataout), .src_rdreq(src_rdreq),
    .sink_full(sink_full), .sink_wrreq(sink_wrreq), .sink_datain(sink_datain),
    .grant_id(grant_id), .busy(busy), .words_fwd(words_fwd)
  );

  // clock / reset
  always #5 clk = ~clk;

  // source FIFO models (non-show-ahead: word appears after the read pulse)
  logic [63:0] mem [NUM_SRC][DEPTH];
  int          head [NUM_SRC];
  int          tail [NUM_SRC];
  logic [63:0] dout [NUM_SRC];

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign src_empty[g]            = (head[g] == tail[g]);
    assign src_dataout[64*g +: 64] = dout[g];
  end

  // scoreboard state
  logic [67:0] exp_q[$];
  logic [67:0] exp_e;
  int model_ptr   = 0;
  int exp_total   = 0;
  int seen_writes = 0;
  int n_cmp = 0;
  int n_err = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endfunction

  function automatic void fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s (t=%0t)", name, $time);
  endfunction

  // monitor: source reads and sink writes
  always @(negedge clk) begin
    if (!reset) begin
      if (src_rdreq != '0) begin
        rd_cnt++;
        check("rdreq_onehot", 64'($onehot(src_rdreq)), 64'd1);
        for (int i = 0; i < NUM_SRC; i++) begin
          if (src_rdreq[i]) begin
            check("rdreq_nonempty", 64'(tail[i] > head[i]), 64'd1);
            if (tail[i] > head[i]) begin
              dout[i] = mem[i][head[i]];
              head[i]++;
            end
          end
        end
      end
      if (sink_wrreq) begin
        wr_cnt++;
        seen_writes++;
        if (exp_q.size() == 0) begin
          fail_now("unexpected_sink_write");
        end else begin
          exp_e = exp_q.pop_front();
          check("sink_datain", sink_datain, exp_e[63:0]);
          check("grant_id", 64'(grant_id), 64'(exp_e[67:64]));
        end
        check("words_fwd_step", 64'(words_fwd), 64'(seen_writes));
      end
    end
  end

  // driver tasks
  task automatic load(input int s, input logic [63:0] w);
    if (head[s] == tail[s]) begin
      head[s] = 0;
      tail[s] = 0;
    end
    mem[s][tail[s]] = w;
    tail[s]++;
  endtask

  function automatic logic [63:0] rand_word();
    return {$urandom, $urandom};
  endfunction

  // Reference: round-robin from model_ptr over a snapshot of FIFO contents,
  // up to BURST_LEN words per grant, pointer moves past each granted source.
  task automatic predict();
    int cnt [NUM_SRC];
    int hd  [NUM_SRC];
    int p, g, take;
    bit any;
    for (int i = 0; i < NUM_SRC; i++) begin
      cnt[i] = tail[i] - head[i];
      hd[i]  = head[i];
    end
    p   = model_ptr;
    any = 1'b1;
    while (any) begin
      any = 1'b0;
      g   = 0;
      for (int k = 0; k < NUM_SRC; k++) begin
        if (!any && cnt[(p + k) % NUM_SRC] > 0) begin
          any = 1'b1;
          g   = (p + k) % NUM_SRC;
        end
      end
      if (any) begin
        take = (cnt[g] < BURST_LEN) ? cnt[g] : BURST_LEN;
        for (int t = 0; t < take; t++) begin
          exp_q.push_back({4'(g), mem[g][hd[g]]});
          hd[g]++;
          cnt[g]--;
          exp_total++;
        end
        p = (g + 1) % NUM_SRC;
      end
    end
    model_ptr = p;
  endtask

  task automatic clear_model();
    exp_q.delete();
    model_ptr   = 0;
    exp_total   = 0;
    seen_writes = 0;
  endtask

  task automatic do_reset();
    enable    = 1'b0;
    sink_full = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    clear_model();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rdreq"}, 64'(src_rdreq), 64'd0);
    check({tag, "_wrreq"}, 64'(sink_wrreq), 64'd0);
    check({tag, "_datain"}, sink_datain, 64'd0);
    check({tag, "_grant"}, 64'(grant_id), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_words"}, 64'(words_fwd), 64'd0);
  endtask

  task automatic wait_idle(input int budget, input bit rand_full);
    bit done;
    done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy && src_empty == '1) begin
        done = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        if (rand_full) sink_full = ($urandom_range(0, 2) == 0);
      end
    end
    sink_full = 1'b0;
    if (!done) fail_now("timeout_waiting_for_idle");
  endtask

  task automatic wait_rdreq(input int budget);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      if (src_rdreq != '0) seen = 1'b1;
    end
    if (!seen) fail_now("timeout_waiting_for_rdreq");
  endtask

  // stimulus
  initial begin
    int rd0, wr0, n;
    logic [63:0] w;
    reset = 1'b1;
    enable = 1'b0;
    sink_full = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      head[i] = 0;
      tail[i] = 0;
      dout[i] = '0;
    end

    // reset state
    repeat (3) @(posedge clk);
    #1 check_outputs_zero("reset");
    reset = 1'b0;

    // one word per source, round-robin order 0,1,2,3
    for (int s = 0; s < NUM_SRC; s++) load(s, rand_word());
    predict();
    enable = 1'b1;
    wait_idle(200, 1'b0);
    check("rr_words_fwd", 64'(words_fwd), 64'd4);
    check("rr_last_grant", 64'(grant_id), 64'd3);

    // six words on source 2: burst of 4, back to idle, then 2
    do_reset();
    for (int k = 0; k < 6; k++) load(2, rand_word());
    predict();
    enable = 1'b1;
    wait_idle(200, 1'b0);
    check("burst_words_fwd", 64'(words_fwd), 64'd6);

    // sink full while in WRITE
    do_reset();
    sink_full = 1'b1;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    load(1, rand_word());
    predict();
    enable = 1'b1;
    repeat (16) @(posedge clk);
    #1;
    check("stall_no_write", 64'(wr_cnt - wr0), 64'd0);
    check("stall_one_read", 64'(rd_cnt - rd0), 64'd1);
    check("stall_datain", sink_datain, 64'd0);
    check("stall_busy", 64'(busy), 64'd1);
    sink_full = 1'b0;
    wait_idle(50, 1'b0);
    check("stall_single_write", 64'(wr_cnt - wr0), 64'd1);
    check("stall_no_extra_read", 64'(rd_cnt - rd0), 64'd1);

    // enable dropped during CAPTURE of the first burst word
    do_reset();
    rd0 = rd_cnt;
    for (int k = 0; k < 3; k++) load(2, rand_word());
    enable = 1'b1;
    wait_rdreq(20);
    @(posedge clk);
    #1 enable = 1'b0;
    exp_q.push_back({4'd2, mem[2][0]});
    exp_total++;
    model_ptr = 3;
    repeat (20) @(posedge clk);
    #1;
    check("endrop_reads", 64'(rd_cnt - rd0), 64'd1);
    check("endrop_written", 64'(exp_q.size()), 64'd0);
    check("endrop_idle", 64'(busy), 64'd0);
    check("endrop_words", 64'(words_fwd), 64'(exp_total));
    predict();
    enable = 1'b1;
    wait_idle(200, 1'b0);
    check("endrop_resume_words", 64'(words_fwd), 64'(exp_total));

    // reset one cycle after a read pulse: word lost, restart at source 0
    load(1, rand_word());
    load(1, rand_word());
    wait_rdreq(20);
    @(posedge clk);
    #1 reset = 1'b1;
    #1 check_outputs_zero("midreset");
    clear_model();
    wr0 = wr_cnt;
    load(0, rand_word());
    predict();
    @(posedge clk);
    #1;
    check("midreset_edge_busy", 64'(busy), 64'd0);
    check("midreset_edge_words", 64'(words_fwd), 64'd0);
    reset = 1'b0;
    wait_idle(200, 1'b0);
    check("midreset_writes", 64'(wr_cnt - wr0), 64'd2);
    check("midreset_words", 64'(words_fwd), 64'd2);

    // quiet-NaN value field
    do_reset();
    rd0 = rd_cnt;
    w = {$urandom, QNAN};
    load(0, w);
    load(1, rand_word());
`ifdef ACCUM_ARB_NAN_FREEZE_EN
    exp_q.push_back({4'd0, w});
    exp_total++;
    enable = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("nan_written", 64'(exp_q.size()), 64'd0);
    check("nan_frozen_busy", 64'(busy), 64'd1);
    check("nan_no_more_reads", 64'(rd_cnt - rd0), 64'd1);
    check("nan_words", 64'(words_fwd), 64'd1);
`else
    predict();
    enable = 1'b1;
    wait_idle(200, 1'b0);
    check("nan_forwarded_words", 64'(words_fwd), 64'd2);
`endif

    // randomized rounds with random sink back-pressure
    do_reset();
    enable = 1'b1;
    for (int r = 0; r < 4; r++) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        n = $urandom_range(0, 6);
        for (int k = 0; k < n; k++) load(s, rand_word());
      end
      predict();
      wait_idle(3000, 1'b1);
      check("random_words_fwd", 64'(words_fwd), 64'(exp_total));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
